pipe_stage_latch: RTL and testbench

- Parametrised inter-stage pipeline register for the 5-stage core. It generalises the fixed EX/MEM-style latch: configurable payload, control and register-index widths.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not stall the upstream stage combinationally.
- Flush inserts a bubble with control forced to a NOP pattern.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_stage_latch.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_latch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline register with a 2-entry skid buffer (main M + skid S).
// Latency: 1 cycle input to output; sustains 1 beat/cycle while out_ready=1.
// Backpressure: in_ready comes from a flop (high while S is empty), never combinationally from out_ready.
// Optional build macro PIPE_LATCH_STATS_EN adds saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_latch #(
  parameter int                DATA_W   = 64,
  parameter int                CTRL_W   = 12,
  parameter int                REG_W    = 3,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [REG_W-1:0]  in_wreg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REG_W-1:0]  out_wreg
`ifdef PIPE_LATCH_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  // Main (head) entry drives the outputs; skid entry catches the beat that
  // arrives while the head is stalled.
  logic              mVld, sVld, inReadyQ;
  logic [DATA_W-1:0] mData, sData;
  logic [CTRL_W-1:0] mCtrl, sCtrl;
  logic [REG_W-1:0]  mWreg, sWreg;

  logic accept, drain;
  logic mVldNxt, sVldNxt;
  logic loadM, loadS, shiftSM;

  assign in_ready  = inReadyQ;
  assign out_valid = mVld;
  assign out_data  = mData;
  assign out_wreg  = mWreg;
  // Bubbles always present the NOP control pattern, even though the data
  // registers keep whatever they last held.
  assign out_ctrl  = mVld ? mCtrl : NOP_CTRL;

  // Next-state decode over {S.valid, M.valid}; flush overrides accept/drain.
  always_comb begin
    accept  = in_valid & inReadyQ;
    drain   = mVld & out_ready;
    mVldNxt = mVld;
    sVldNxt = sVld;
    loadM   = 1'b0;
    loadS   = 1'b0;
    shiftSM = 1'b0;
    if (flush) begin
      mVldNxt = 1'b0;
      sVldNxt = 1'b0;
    end else begin
      case ({sVld, mVld})
        2'b00: begin
          if (accept) begin
            mVldNxt = 1'b1;
            loadM   = 1'b1;
          end
        end
        2'b01: begin
          if (accept && drain) begin
            loadM = 1'b1;
          end else if (accept) begin
            sVldNxt = 1'b1;
            loadS   = 1'b1;
          end else if (drain) begin
            mVldNxt = 1'b0;
          end
        end
        2'b11: begin
          if (drain) begin
            sVldNxt = 1'b0;
            shiftSM = 1'b1;
          end
        end
        default: begin
          // Skid-only occupancy is unreachable; fall back to empty.
          mVldNxt = 1'b0;
          sVldNxt = 1'b0;
        end
      endcase
    end
  end

  // State and storage registers; reset clears everything, flush only the valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      mVld     <= 1'b0;
      sVld     <= 1'b0;
      inReadyQ <= 1'b1;
      mData    <= '0;
      mCtrl    <= '0;
      mWreg    <= '0;
      sData    <= '0;
      sCtrl    <= '0;
      sWreg    <= '0;
    end else begin
      mVld     <= mVldNxt;
      sVld     <= sVldNxt;
      inReadyQ <= ~sVldNxt;
      if (loadM) begin
        mData <= in_data;
        mCtrl <= in_ctrl;
        mWreg <= in_wreg;
      end else if (shiftSM) begin
        mData <= sData;
        mCtrl <= sCtrl;
        mWreg <= sWreg;
      end
      if (loadS) begin
        sData <= in_data;
        sCtrl <= in_ctrl;
        sWreg <= in_wreg;
      end
    end
  end

`ifdef PIPE_LATCH_STATS_EN
  // Saturating occupancy statistics; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (mVld && !out_ready && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (!mVld && bubble_cnt != 16'hFFFF) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch: reset, streaming, back-pressure, flush.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled there too.
module tb_pipe_stage_latch;

  localparam int          DATA_W = 64;
  localparam int          CTRL_W = 12;
  localparam int          REG_W  = 3;
  localparam logic [11:0] NOP    = 12'hA5A;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [REG_W-1:0]  in_wreg;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [REG_W-1:0]  out_wreg;
`ifdef PIPE_LATCH_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pipe_stage_latch #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_W(REG_W), .NOP_CTRL(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wreg(in_wreg),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wreg(out_wreg)
`ifdef PIPE_LATCH_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control pattern tied to the payload so every field can be checked.
  function automatic logic [CTRL_W-1:0] ctrlOf(input logic [DATA_W-1:0] d);
    return 12'h100 | {4'h0, d[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = ctrlOf(d);
    in_wreg  = d[REG_W-1:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    send(1'b1, 64'h77);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        rst = 1'b0;
        send(1'b0, 64'h0);
      end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset%0d out_valid got %b want 0", i, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset%0d in_ready got %b want 1", i, in_ready); end
      checks++; if (out_ctrl !== NOP) begin errors++; $display("FAIL reset%0d out_ctrl got %h want %h", i, out_ctrl, NOP); end
      checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset%0d out_data got %h want 0", i, out_data); end
      checks++; if (out_wreg !== 3'h0) begin errors++; $display("FAIL reset%0d out_wreg got %h want 0", i, out_wreg); end
    end
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] exp;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp = 64'(i);
      send(1'b1, exp);
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream%0d out_valid got %b want 1", i, out_valid); end
      checks++; if (out_data !== exp) begin errors++; $display("FAIL stream%0d out_data got %h want %h", i, out_data, exp); end
      checks++; if (out_ctrl !== ctrlOf(exp)) begin errors++; $display("FAIL stream%0d out_ctrl got %h want %h", i, out_ctrl, ctrlOf(exp)); end
      checks++; if (out_wreg !== exp[2:0]) begin errors++; $display("FAIL stream%0d out_wreg got %h want %h", i, out_wreg, exp[2:0]); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream%0d in_ready got %b want 1", i, in_ready); end
    end
    send(1'b0, 64'h0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end out_valid got %b want 0", out_valid); end
    checks++; if (out_ctrl !== NOP) begin errors++; $display("FAIL stream_end out_ctrl got %h want %h", out_ctrl, NOP); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(1'b1, 64'hA);
    tick();
    checks++; if (out_data !== 64'hA || out_valid !== 1'b1) begin errors++; $display("FAIL bp_one data/valid got %h/%b want a/1", out_data, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_one in_ready got %b want 1", in_ready); end
    send(1'b1, 64'hB);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_two in_ready got %b want 0", in_ready); end
    checks++; if (out_data !== 64'hA) begin errors++; $display("FAIL bp_two out_data got %h want a", out_data); end
    checks++; if (out_ctrl !== ctrlOf(64'hA) || out_wreg !== 3'h2) begin errors++; $display("FAIL bp_two ctrl/wreg got %h/%h want %h/2", out_ctrl, out_wreg, ctrlOf(64'hA)); end
    // Offered beat must be refused while full.
    send(1'b1, 64'hD);
    tick();
    checks++; if (out_data !== 64'hA || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold data/in_ready got %h/%b want a/0", out_data, in_ready); end
    send(1'b0, 64'h0);
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 64'hB) begin errors++; $display("FAIL bp_drain1 valid/data got %b/%h want 1/b", out_valid, out_data); end
    checks++; if (out_ctrl !== ctrlOf(64'hB) || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain1 ctrl/in_ready got %h/%b want %h/1", out_ctrl, in_ready, ctrlOf(64'hB)); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain2 out_valid got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(1'b1, 64'hA); tick();
    send(1'b1, 64'hB); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre in_ready got %b want 0", in_ready); end
    flush = 1'b1;
    send(1'b1, 64'hC);
    tick();
    flush = 1'b0;
    send(1'b0, 64'h0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid got %b want 0", out_valid); end
    checks++; if (out_ctrl !== NOP) begin errors++; $display("FAIL flush out_ctrl got %h want %h", out_ctrl, NOP); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready got %b want 1", in_ready); end
    checks++; if (out_data !== 64'hA) begin errors++; $display("FAIL flush data_kept got %h want a", out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_post out_valid got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_drain();
    out_ready = 1'b0;
    send(1'b1, 64'h5); tick();
    send(1'b0, 64'h0);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 64'h5) begin errors++; $display("FAIL fdrain_xfer valid/data got %b/%h want 1/5", out_valid, out_data); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fdrain_empty valid/in_ready got %b/%b want 0/1", out_valid, in_ready); end
    send(1'b1, 64'h6); tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 64'h6) begin errors++; $display("FAIL fdrain_next valid/data got %b/%h want 1/6", out_valid, out_data); end
    send(1'b0, 64'h0); tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] expD [5] = '{64'h11, 64'h11, 64'h12, 64'h13, 64'h0};
    logic              expV [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic              expR [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [DATA_W-1:0] inD  [5] = '{64'h11, 64'h12, 64'h13, 64'h13, 64'h0};
    logic              inV  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic              oR   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b0;
    send(1'b1, 64'h10); tick();
    for (int i = 0; i < 5; i++) begin
      send(inV[i], inD[i]);
      out_ready = oR[i];
      tick();
      checks++; if (out_valid !== expV[i] || (expV[i] && out_data !== expD[i])) begin errors++; $display("FAIL b2b%0d valid/data got %b/%h want %b/%h", i, out_valid, out_data, expV[i], expD[i]); end
      checks++; if (in_ready !== expR[i]) begin errors++; $display("FAIL b2b%0d in_ready got %b want %b", i, in_ready, expR[i]); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_after_data();
    send(1'b1, 64'h99); tick();
    send(1'b0, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_data valid/in_ready got %b/%b want 0/1", out_valid, in_ready); end
    checks++; if (out_data !== 64'h0 || out_wreg !== 3'h0) begin errors++; $display("FAIL rst_data data/wreg got %h/%h want 0/0", out_data, out_wreg); end
  endtask

`ifdef PIPE_LATCH_STATS_EN
  task automatic test_stats();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    send(1'b0, 64'h0);
    tick();
    rst = 1'b0;
    checks++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin errors++; $display("FAIL stats_rst stall/bubble got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
    repeat (4) tick();
    send(1'b1, 64'h20); tick();
    send(1'b0, 64'h0);
    repeat (3) tick();
    checks++; if (bubble_cnt !== 16'd5) begin errors++; $display("FAIL stats_bubble got %0d want 5", bubble_cnt); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stats_stall got %0d want 3", stall_cnt); end
    out_ready = 1'b1; tick();
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (65540) tick();
    checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_sat bubble got %h want ffff", bubble_cnt); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stats_keep stall got %0d want 3", stall_cnt); end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_drain();
    test_back_to_back();
    test_reset_after_data();
`ifdef PIPE_LATCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
